// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the hash core output path.
package hash_pkg;

  localparam int STATE_BITS = 1600;
  localparam int RATE_BITS  = 576;
  localparam int WORD_BITS  = 64;
  localparam int RATE_WORDS = RATE_BITS / WORD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PERM,
    EMIT,
    REQ
  } squeeze_state_t;

endpackage

// File: rtl/squeeze_buf.sv
// Rate-block capture register with a word-select read port.
// Bytes past rd_bytes are zeroed from the LSB side.
module squeeze_buf #(
  parameter int RATE_BITS = 576,
  parameter int WORD_BITS = 64,
  parameter int IDX_W     = 4,
  parameter int BYTES_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [RATE_BITS-1:0] rate_in,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [BYTES_W-1:0]   rd_bytes,
  output logic [WORD_BITS-1:0] rd_word
);

  localparam int NUM_WORDS = RATE_BITS / WORD_BITS;
  localparam int WBYTES    = WORD_BITS / 8;

  logic [WORD_BITS-1:0] words_q [NUM_WORDS];
  logic [WORD_BITS-1:0] sel_word;

  // Word 0 is the most significant slice of the rate block.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_WORDS; k++) words_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_WORDS; k++)
        words_q[k] <= rate_in[RATE_BITS-1-k*WORD_BITS -: WORD_BITS];
    end
  end

  always_comb begin
    sel_word = '0;
    if (int'(rd_idx) < NUM_WORDS) sel_word = words_q[rd_idx];
    rd_word = sel_word;
    for (int b = 0; b < WBYTES; b++) begin
      if (b >= int'(rd_bytes)) rd_word[WORD_BITS-1-8*b -: 8] = 8'h00;
    end
  end

endmodule

// File: rtl/squeezer.sv
// Streams the rate part of the permutation state as handshaked words,
// requesting extra permutations until the requested byte count is met.
module squeezer #(
  parameter int RATE_BITS = hash_pkg::RATE_BITS,
  parameter int WORD_BITS = hash_pkg::WORD_BITS,
  parameter int LEN_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             out_len,
  input  logic [1599:0]                f_out,
  input  logic                         f_out_ready,
  output logic                         f_req,
  output logic [WORD_BITS-1:0]         dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_last,
  output logic [$clog2(WORD_BITS/8):0] dout_bytes,
  output logic                         busy,
  output logic                         done
);

  import hash_pkg::*;

  localparam int NUM_WORDS = RATE_BITS / WORD_BITS;
  localparam int WBYTES    = WORD_BITS / 8;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BYTES_W   = $clog2(WBYTES) + 1;

  squeeze_state_t       state_q, state_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 capture;
  logic                 word_last;
  logic [BYTES_W-1:0]   word_bytes;
  logic [WORD_BITS-1:0] buf_word;

  always_comb begin
    word_last  = (remaining_q <= LEN_W'(WBYTES));
    word_bytes = word_last ? BYTES_W'(remaining_q) : BYTES_W'(WBYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len != '0) begin
            remaining_d = out_len;
            state_d     = WAIT_PERM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_PERM: begin
        if (f_out_ready) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (dout_ready) begin
          remaining_d = remaining_q - LEN_W'(word_bytes);
          if (word_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      REQ:     state_d = WAIT_PERM;
      default: state_d = IDLE;
    endcase
  end

  squeeze_buf #(
    .RATE_BITS(RATE_BITS),
    .WORD_BITS(WORD_BITS),
    .IDX_W    (IDX_W),
    .BYTES_W  (BYTES_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .rate_in (f_out[1599 -: RATE_BITS]),
    .rd_idx  (idx_q),
    .rd_bytes(word_bytes),
    .rd_word (buf_word)
  );

  // Word outputs are forced to zero outside EMIT so idle outputs read as 0.
  assign dout_valid = (state_q == EMIT);
  assign f_req      = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign dout       = dout_valid ? buf_word : '0;
  assign dout_bytes = dout_valid ? word_bytes : '0;
  assign dout_last  = dout_valid & word_last;

endmodule

// File: tb/tb_squeezer.sv
// Randomized self-checking bench for squeezer against a byte-stream model.
module tb_squeezer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   out_len = '0;
  logic [1599:0] f_out = '0;
  logic          f_out_ready = 1'b0;
  logic          f_req;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic [3:0]    dout_bytes;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  squeezer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .out_len    (out_len),
    .f_out      (f_out),
    .f_out_ready(f_out_ready),
    .f_req      (f_req),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout_bytes (dout_bytes),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, dout_valid, 0);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_freq"},  f_req, 0);
    checkOutput({tag, "_done"},  done, 0);
    checkOutput({tag, "_dout"},  dout, 0);
    checkOutput({tag, "_bytes"}, dout_bytes, 0);
    checkOutput({tag, "_last"},  dout_last, 0);
  endtask

  // One squeeze of len bytes: the expected output is simply the first len
  // bytes of the concatenated rate blocks, chopped into 8-byte words.
  task automatic applyStimulus(input int len, input int ready_pct, input bit noise);
    logic [1599:0] st [$];
    logic [7:0]    eb [$];
    int blocks, words, fed, reqs, n, cyc, wait_cnt, nb;
    bit pending, finished, done_seen, expect_valid, feed_now, held;
    logic [63:0] held_dout, exp_word;
    logic [3:0]  held_bytes;

    blocks = (len + 71) / 72;
    words  = (len + 7) / 8;
    for (int b = 0; b < blocks; b++) begin
      st.push_back(rand_state());
      for (int j = 0; j < 72; j++)
        if (eb.size() < len) eb.push_back(st[b][1599-8*j -: 8]);
    end
    fed = 0; reqs = 0; n = 0; cyc = 0;
    pending = 1; finished = 0; done_seen = 0; expect_valid = 0; held = 0;
    held_dout = '0; held_bytes = '0;
    wait_cnt = $urandom_range(0, 3);

    @(negedge clk);
    start = 1'b1;
    out_len = 16'(len);
    @(negedge clk);
    while (!done_seen && cyc < 3000) begin
      start = 1'b0;
      f_out_ready = 1'b0;
      feed_now = 0;
      if (pending && fed < blocks) begin
        if (wait_cnt == 0) begin
          f_out = st[fed];
          f_out_ready = 1'b1;
          fed++;
          pending = 0;
          feed_now = 1;
        end else begin
          wait_cnt--;
        end
      end else if (noise && !pending && !finished && ($urandom % 4) == 0) begin
        f_out = rand_state();
        f_out_ready = 1'b1;
      end
      if (noise && !finished && ($urandom % 5) == 0) begin
        start = 1'b1;
        out_len = 16'($urandom);
      end
      dout_ready = ($urandom_range(1, 100) <= ready_pct);
      #1;
      if (expect_valid) checkOutput("valid_latency", dout_valid, 1);
      expect_valid = feed_now;
      if (finished) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after", busy, 0);
        done_seen = 1;
      end else begin
        checkOutput("busy", busy, 1);
        checkOutput("no_early_done", done, 0);
        if (f_req) begin
          reqs++;
          checkOutput("f_req_needed", fed < blocks, 1);
          pending = 1;
          wait_cnt = $urandom_range(0, 3);
        end
        if (held) begin
          checkOutput("hold_valid", dout_valid, 1);
          checkOutput("hold_dout", dout, held_dout);
          checkOutput("hold_bytes", dout_bytes, held_bytes);
        end
        if (dout_valid && dout_ready) begin
          nb = (len - 8*n < 8) ? len - 8*n : 8;
          exp_word = '0;
          for (int i = 0; i < nb; i++) exp_word[63-8*i -: 8] = eb[8*n+i];
          checkOutput("word_data", dout, exp_word);
          checkOutput("word_bytes", dout_bytes, nb);
          checkOutput("word_last", dout_last, (8*n + 8 >= len));
          n++;
          if (n >= words) finished = 1;
        end
        held = dout_valid && !dout_ready;
        held_dout = dout;
        held_bytes = dout_bytes;
      end
      if (!done_seen) @(negedge clk);
      cyc++;
    end
    checkOutput("no_timeout", done_seen, 1);
    checkOutput("word_count", n, words);
    checkOutput("f_req_count", reqs, blocks - 1);
    start = 1'b0;
    f_out_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("done_one_cycle", done, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    applyStimulus(32, 100, 0);
    applyStimulus(72, 100, 0);
    applyStimulus(75, 100, 0);
    applyStimulus(16, 40, 0);

    // Zero-length request
    @(negedge clk);
    start = 1'b1;
    out_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("zero_len_done", done, 1);
    checkOutput("zero_len_busy", busy, 0);
    @(negedge clk);
    #1;
    checkOutput("zero_len_done_drop", done, 0);

    // Spurious permutation result while idle
    @(negedge clk);
    f_out = rand_state();
    f_out_ready = 1'b1;
    @(negedge clk);
    f_out_ready = 1'b0;
    #1;
    checkOutput("spurious_valid", dout_valid, 0);
    checkOutput("spurious_busy", busy, 0);

    // Reset in the middle of emitting a block
    @(negedge clk);
    start = 1'b1;
    out_len = 16'd200;
    dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_out = rand_state();
    f_out_ready = 1'b1;
    @(negedge clk);
    f_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_valid", dout_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_reset_done", done, 0);
    checkOutput("post_reset_busy", busy, 0);
    applyStimulus(8, 100, 0);

    for (int t = 0; t < 20; t++)
      applyStimulus($urandom_range(1, 300), $urandom_range(30, 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
